// File: rtl/gmii_tx_framer_if.sv
// Byte-stream input and GMII output bundle of the transmit framer.
// master = encapsulation side / observer, slave = the framer itself.
interface gmii_tx_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, gmii_txd, gmii_tx_en, gmii_tx_er, busy, frame_done, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, gmii_txd, gmii_tx_en, gmii_tx_er, busy, frame_done, frame_err
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, data, zero pad, CRC-32 FCS, inter-frame gap,
// with tx_er signalling for underrun and oversize frames.
module gmii_tx_framer #(
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned MAX_FRAME    = 1514,
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned PREAMBLE_LEN = 7
) (
  input logic              eth_tx_clk,
  input logic              eth_rst,
  gmii_tx_framer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StSfd, StData, StPad, StFcs, StDrop, StIfg
  } state_e;

  localparam int unsigned CntW = 16;
  // IDLE emits the first preamble byte, so PREAMBLE covers the remaining LEN-1.
  localparam logic [CntW-1:0] PreLast = CntW'(PREAMBLE_LEN - 2);
  localparam logic [CntW-1:0] IfgLast = CntW'(IFG_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [10:0]     MinLen  = 11'(MIN_FRAME);
  localparam logic [10:0]     MaxLen  = 11'(MAX_FRAME);

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [10:0]     len_q, len_d;
  logic [31:0]     crc_q, crc_d;
  logic [7:0]      txd_q, txd_d;
  logic            tx_en_q, tx_en_d;
  logic            tx_er_q, tx_er_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [10:0] len_inc;
  logic [31:0] fcs_word;

  assign len_inc  = len_q + 11'd1;
  assign fcs_word = ~crc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    crc_d   = crc_q;
    txd_d   = 8'h00;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StPreamble;
          txd_d   = 8'h55;
          tx_en_d = 1'b1;
          cnt_d   = '0;
          len_d   = '0;
          crc_d   = 32'hFFFF_FFFF;
        end
      end
      StPreamble: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
        if (cnt_q == PreLast) state_d = StSfd;
        else                  cnt_d   = cnt_q + CntOne;
      end
      StSfd: begin
        txd_d   = 8'hD5;
        tx_en_d = 1'b1;
        state_d = StData;
      end
      StData: begin
        cnt_d   = '0;
        tx_en_d = 1'b1;
        // Underrun or oversize: one tx_er cycle, then discard the rest of the frame.
        if (!bus.in_valid || (len_q == MaxLen)) begin
          tx_er_d = 1'b1;
          err_d   = 1'b1;
          state_d = (bus.in_valid && bus.in_last) ? StIfg : StDrop;
        end else begin
          txd_d = bus.in_data;
          crc_d = crc_next(crc_q, bus.in_data);
          len_d = len_inc;
          if (bus.in_last) state_d = (len_inc < MinLen) ? StPad : StFcs;
        end
      end
      StPad: begin
        tx_en_d = 1'b1;
        crc_d   = crc_next(crc_q, 8'h00);
        len_d   = len_inc;
        if (len_inc == MinLen) begin
          state_d = StFcs;
          cnt_d   = '0;
        end
      end
      StFcs: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q[1:0] == 2'd3) begin
          state_d = StIfg;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDrop: begin
        if (bus.in_valid && bus.in_last) begin
          state_d = StIfg;
          cnt_d   = '0;
        end
      end
      StIfg: begin
        if (cnt_q == IfgLast) state_d = StIdle;
        else                  cnt_d   = cnt_q + CntOne;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
    if (eth_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      txd_q   <= 8'h00;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = (state_q == StData) || (state_q == StDrop);
  assign bus.busy       = (state_q != StIdle);
  assign bus.gmii_txd   = txd_q;
  assign bus.gmii_tx_en = tx_en_q;
  assign bus.gmii_tx_er = tx_er_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;

endmodule
